vscale_htif_pcr_arb: RTL and testbench

- Host-side arbiter and sequencer for the single HTIF PCR request/response port of vscale_sim_top.
- Shares that port between NUM_REQ host requesters, for example a tohost poller and a fromhost writer.
- Allows one outstanding PCR transaction at a time, with round-robin grant and the response routed back to the granted requester.
- Includes an optional response timeout so that a hung core cannot deadlock the host side.

---
 rtl/vscale_htif_pcr_arb_if.sv | 37 +++
 rtl/vscale_htif_pcr_arb.sv | 107 ++++++++++
 tb/tb_vscale_htif_pcr_arb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_htif_pcr_arb_if.sv
// vscale_htif_pcr_arb_if: host requester bus and downstream HTIF PCR port seen by the arbiter
interface vscale_htif_pcr_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic                      htif_pcr_req_valid;
    logic                      htif_pcr_req_ready;
    logic                      htif_pcr_req_rw;
    logic [ADDR_W-1:0]         htif_pcr_req_addr;
    logic [DATA_W-1:0]         htif_pcr_req_data;
    logic                      htif_pcr_resp_valid;
    logic                      htif_pcr_resp_ready;
    logic [DATA_W-1:0]         htif_pcr_resp_data;
    modport slave (
        input  req_valid, req_rw, req_addr, req_data, resp_ready,
               htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
        output req_ready, resp_valid, resp_data,
               htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
               htif_pcr_resp_ready
    );
    modport master (
        output req_valid, req_rw, req_addr, req_data, resp_ready,
               htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
        input  req_ready, resp_valid, resp_data,
               htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
               htif_pcr_resp_ready
    );
endinterface

// File: rtl/vscale_htif_pcr_arb.sv
// vscale_htif_pcr_arb: round-robin arbiter sharing one HTIF PCR port, one transaction in flight, with response timeout
module vscale_htif_pcr_arb #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 64,
    parameter int RESP_TIMEOUT = 1024,
    localparam int GW          = $clog2(NUM_REQ),
    localparam int TW          = RESP_TIMEOUT > 1 ? $clog2(RESP_TIMEOUT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    vscale_htif_pcr_arb_if.slave   io,
    output logic                   o_busy,
    output logic                   o_timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
    state_t            r_state, w_state_nxt;
    logic [GW-1:0]     r_rr_ptr, r_gnt, w_win;
    logic              w_win_vld, w_expire;
    logic              r_rw, r_timeout_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [TW-1:0]     r_timer;
    // first valid requester scanning upward from the round-robin pointer
    always_comb begin
        w_win     = r_rr_ptr;
        w_win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (io.req_valid[GW'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
                w_win     = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
                w_win_vld = 1'b1;
            end
        end
    end
    // next state and handshake outputs; everything is forced quiet while reset is held
    always_comb begin
        w_state_nxt            = r_state;
        w_expire               = 1'b0;
        io.req_ready           = '0;
        io.resp_valid          = '0;
        io.htif_pcr_req_valid  = 1'b0;
        io.htif_pcr_resp_ready = 1'b0;
        case (r_state)
            IDLE: begin
                io.req_ready[w_win]    = w_win_vld;
                io.htif_pcr_resp_ready = 1'b1;
                w_state_nxt            = w_win_vld ? ISSUE : IDLE;
            end
            ISSUE: begin
                io.htif_pcr_req_valid  = 1'b1;
                io.htif_pcr_resp_ready = 1'b1;
                w_state_nxt            = io.htif_pcr_req_ready ? WAIT : ISSUE;
            end
            WAIT: begin
                io.htif_pcr_resp_ready = 1'b1;
                w_expire               = RESP_TIMEOUT != 0 && r_timer == TW'(RESP_TIMEOUT - 1) && !io.htif_pcr_resp_valid;
                w_state_nxt            = (io.htif_pcr_resp_valid || w_expire) ? DELIVER : WAIT;
            end
            DELIVER: begin
                io.resp_valid[r_gnt] = 1'b1;
                w_state_nxt          = io.resp_ready[r_gnt] ? IDLE : DELIVER;
            end
        endcase
        if (reset) begin
            io.req_ready           = '0;
            io.resp_valid          = '0;
            io.htif_pcr_req_valid  = 1'b0;
            io.htif_pcr_resp_ready = 1'b0;
        end
    end
    assign io.htif_pcr_req_rw   = r_rw & ~reset;
    assign io.htif_pcr_req_addr = reset ? '0 : r_addr;
    assign io.htif_pcr_req_data = reset ? '0 : r_data;
    assign io.resp_data         = reset ? '0 : r_data;
    assign o_busy               = r_state != IDLE;
    assign o_timeout_err        = r_timeout_err;
    // state, latched request/response fields, wait timer and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_gnt         <= '0;
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= r_state == WAIT ? r_timer + 1'b1 : '0;
            if (r_state == IDLE && w_win_vld) begin
                r_gnt  <= w_win;
                r_rw   <= io.req_rw[w_win];
                r_addr <= io.req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                r_data <= io.req_data[int'(w_win)*DATA_W +: DATA_W];
            end
            if (r_state == WAIT && io.htif_pcr_resp_valid)
                r_data <= io.htif_pcr_resp_data;
            if (w_expire) begin
                r_data        <= '0;
                r_timeout_err <= 1'b1;
            end
            if (r_state == DELIVER && io.resp_ready[r_gnt])
                r_rr_ptr <= int'(r_gnt) == NUM_REQ - 1 ? '0 : r_gnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_vscale_htif_pcr_arb.sv
// tb_vscale_htif_pcr_arb: directed scenarios plus randomized traffic against a transaction-level model
module tb_vscale_htif_pcr_arb;
    localparam int N = 2;
    logic clk, reset, busy, terr;
    int checks, errors;
    vscale_htif_pcr_arb_if #(.NUM_REQ(N), .ADDR_W(12), .DATA_W(64)) bus();
    vscale_htif_pcr_arb #(.NUM_REQ(N), .ADDR_W(12), .DATA_W(64), .RESP_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .io(bus), .o_busy(busy), .o_timeout_err(terr));
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    // completes a transaction currently in ISSUE: accept, respond next cycle, then deliver
    task automatic serve(input logic [63:0] d);
        bus.htif_pcr_req_ready = 1'b1;
        @(negedge clk);
        bus.htif_pcr_req_ready  = 1'b0;
        bus.htif_pcr_resp_valid = 1'b1;
        bus.htif_pcr_resp_data  = d;
        @(negedge clk);
        bus.htif_pcr_resp_valid = 1'b0;
        bus.resp_ready          = '1;
        @(negedge clk);
        bus.resp_ready = '0;
    endtask
    task automatic test_reset();
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.htif_pcr_resp_valid = 1'b1;
        bus.htif_pcr_req_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", bus.req_ready); end
        checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b exp 00", bus.resp_valid); end
        checks++; if (bus.htif_pcr_req_valid !== 1'b0 || bus.htif_pcr_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_htif got %b%b exp 00", bus.htif_pcr_req_valid, bus.htif_pcr_resp_ready); end
        checks++; if (bus.htif_pcr_req_addr !== 12'h0 || bus.resp_data !== 64'h0) begin errors++; $display("FAIL rst_fields got %h %h exp 0", bus.htif_pcr_req_addr, bus.resp_data); end
        bus.req_valid = '0;
        bus.htif_pcr_resp_valid = 1'b0;
        bus.htif_pcr_req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || terr !== 1'b0) begin errors++; $display("FAIL rst_status got busy %b terr %b exp 0 0", busy, terr); end
    endtask
    task automatic test_single_read();
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_rw = 2'b00;
        bus.req_addr[11:0] = 12'h780;
        bus.htif_pcr_req_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rd_grant got %b exp 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++; if (bus.htif_pcr_req_valid !== 1'b1 || bus.htif_pcr_req_addr !== 12'h780 || bus.htif_pcr_req_rw !== 1'b0) begin errors++; $display("FAIL rd_issue got v%b a%h rw%b exp v1 a780 rw0", bus.htif_pcr_req_valid, bus.htif_pcr_req_addr, bus.htif_pcr_req_rw); end
        @(negedge clk);
        bus.htif_pcr_req_ready = 1'b0;
        bus.htif_pcr_resp_valid = 1'b1;
        bus.htif_pcr_resp_data = 64'h1;
        #1;
        checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rd_early_resp got %b exp 00", bus.resp_valid); end
        @(negedge clk);
        bus.htif_pcr_resp_valid = 1'b0;
        bus.resp_ready = 2'b01;
        #1;
        checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'h1 || busy !== 1'b1) begin errors++; $display("FAIL rd_deliver got v%b d%h busy%b exp v01 d1 busy1", bus.resp_valid, bus.resp_data, busy); end
        @(negedge clk);
        bus.resp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0 || bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rd_done got busy%b v%b exp busy0 v00", busy, bus.resp_valid); end
    endtask
    task automatic test_write();
        @(negedge clk);
        bus.req_valid = 2'b10;
        bus.req_rw = 2'b10;
        bus.req_addr[12 +: 12] = 12'h781;
        bus.req_data[64 +: 64] = 64'hDEADBEEF;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL wr_grant got %b exp 10", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++; if (bus.htif_pcr_req_valid !== 1'b1 || bus.htif_pcr_req_rw !== 1'b1 || bus.htif_pcr_req_addr !== 12'h781 || bus.htif_pcr_req_data !== 64'hDEADBEEF) begin errors++; $display("FAIL wr_issue got v%b rw%b a%h d%h exp v1 rw1 a781 dDEADBEEF", bus.htif_pcr_req_valid, bus.htif_pcr_req_rw, bus.htif_pcr_req_addr, bus.htif_pcr_req_data); end
        serve(64'h5);
    endtask
    task automatic test_contention();
        @(negedge clk);
        bus.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++; if (bus.req_ready !== (t % 2 == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", t, bus.req_ready, (t % 2 == 0 ? 2'b01 : 2'b10)); end
            @(negedge clk);
            #1;
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL cont_busy_ready%0d got %b exp 00", t, bus.req_ready); end
            serve(64'(t));
        end
        bus.req_valid = '0;
    endtask
    task automatic test_back_to_back();
        logic [63:0] d1, d2;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        @(negedge clk);
        bus.req_valid = 2'b10;
        bus.req_rw = 2'b10;
        bus.req_addr[12 +: 12] = 12'h123;
        bus.req_data[64 +: 64] = d1;
        bus.htif_pcr_req_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant got %b exp 10", bus.req_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req_valid = 2'b01;
            #1;
            checks++; if (bus.htif_pcr_req_valid !== 1'b1 || bus.htif_pcr_req_rw !== 1'b1 || bus.htif_pcr_req_addr !== 12'h123 || bus.htif_pcr_req_data !== d1 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold%0d got v%b rw%b a%h d%h rdy%b exp v1 rw1 a123 d%h rdy00", k, bus.htif_pcr_req_valid, bus.htif_pcr_req_rw, bus.htif_pcr_req_addr, bus.htif_pcr_req_data, bus.req_ready, d1); end
        end
        @(negedge clk);
        bus.htif_pcr_req_ready = 1'b1;
        @(negedge clk);
        bus.htif_pcr_req_ready = 1'b0;
        bus.htif_pcr_resp_valid = 1'b1;
        bus.htif_pcr_resp_data = d2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.htif_pcr_resp_valid = 1'b0;
            bus.resp_ready = 2'b01;
            #1;
            checks++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== d2 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_deliver%0d got v%b d%h rdy%b exp v10 d%h rdy00", k, bus.resp_valid, bus.resp_data, bus.req_ready, d2); end
        end
        @(negedge clk);
        bus.resp_ready = 2'b10;
        #1;
        checks++; if (bus.resp_valid !== 2'b10) begin errors++; $display("FAIL bp_final got %b exp 10", bus.resp_valid); end
        @(negedge clk);
        bus.resp_ready = '0;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_grant got %b exp 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        serve(64'h9);
    endtask
    task automatic test_timeout();
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_rw = 2'b00;
        bus.htif_pcr_req_ready = 1'b1;
        bus.htif_pcr_resp_data = 64'hFFFF;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL to_grant got %b exp 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.htif_pcr_req_ready = 1'b0;
            #1;
            checks++; if (bus.resp_valid !== 2'b00 || busy !== 1'b1 || terr !== 1'b0) begin errors++; $display("FAIL to_wait%0d got v%b busy%b terr%b exp v00 busy1 terr0", k, bus.resp_valid, busy, terr); end
        end
        @(negedge clk);
        bus.resp_ready = 2'b01;
        #1;
        checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'h0 || terr !== 1'b1) begin errors++; $display("FAIL to_deliver got v%b d%h terr%b exp v01 d0 terr1", bus.resp_valid, bus.resp_data, terr); end
        @(negedge clk);
        bus.resp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        bus.htif_pcr_resp_valid = 1'b1;
        bus.htif_pcr_resp_data = 64'h77;
        #1;
        checks++; if (bus.htif_pcr_resp_ready !== 1'b1) begin errors++; $display("FAIL to_late_drain got %b exp 1", bus.htif_pcr_resp_ready); end
        @(negedge clk);
        bus.htif_pcr_resp_valid = 1'b0;
        #1;
        checks++; if (bus.resp_valid !== 2'b00 || busy !== 1'b0 || terr !== 1'b1) begin errors++; $display("FAIL to_late_drop got v%b busy%b terr%b exp v00 busy0 terr1", bus.resp_valid, busy, terr); end
    endtask
    task automatic test_reset_mid_wait();
        @(negedge clk);
        bus.req_valid = 2'b10;
        bus.htif_pcr_req_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        bus.htif_pcr_req_ready = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_in_wait got busy %b exp 1", busy); end
        @(negedge clk);
        reset = 1'b1;
        bus.htif_pcr_resp_valid = 1'b1;
        bus.resp_ready = '1;
        #1;
        checks++; if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b00 || bus.htif_pcr_req_valid !== 1'b0 || bus.htif_pcr_resp_ready !== 1'b0) begin errors++; $display("FAIL rw_gated got rv%b rr%b hv%b hr%b exp all 0", bus.resp_valid, bus.req_ready, bus.htif_pcr_req_valid, bus.htif_pcr_resp_ready); end
        @(negedge clk);
        reset = 1'b0;
        bus.htif_pcr_resp_valid = 1'b0;
        bus.resp_ready = '0;
        bus.req_valid = 2'b11;
        #1;
        checks++; if (busy !== 1'b0 || terr !== 1'b0 || bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rw_after got busy%b terr%b v%b exp 0 0 00", busy, terr, bus.resp_valid); end
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rw_ptr got %b exp 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        serve(64'h3);
    endtask
    task automatic test_random();
        int ptr, phase, cur, cd;
        logic [1:0] pend, exp_rdy, exp_rv;
        logic [11:0] exp_a;
        logic [63:0] exp_wd, exp_d;
        logic exp_rw, resp_drv, found;
        ptr = 0; phase = 0; cur = 0; cd = 0; pend = '0;
        exp_a = '0; exp_wd = '0; exp_d = '0; exp_rw = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    bus.req_rw[i] = 1'($urandom);
                    bus.req_addr[i*12 +: 12] = 12'($urandom);
                    bus.req_data[i*64 +: 64] = {$urandom, $urandom};
                end
            end
            bus.req_valid = pend;
            bus.resp_ready = 2'($urandom);
            bus.htif_pcr_req_ready = 1'($urandom);
            resp_drv = phase == 2 && cd == 0;
            bus.htif_pcr_resp_valid = resp_drv || (phase < 2 && $urandom_range(0, 7) == 0);
            bus.htif_pcr_resp_data = {$urandom, $urandom};
            #1;
            exp_rdy = '0;
            found = 1'b0;
            if (phase == 0)
                for (int k = 0; k < N; k++)
                    if (!found && pend[(ptr + k) % N]) begin
                        exp_rdy[(ptr + k) % N] = 1'b1;
                        found = 1'b1;
                    end
            exp_rv = '0;
            if (phase == 3) exp_rv[cur] = 1'b1;
            checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_req_ready cyc %0d got %b exp %b", cyc, bus.req_ready, exp_rdy); end
            checks++; if (bus.htif_pcr_req_valid !== (phase == 1)) begin errors++; $display("FAIL rnd_htif_req_valid cyc %0d got %b exp %b", cyc, bus.htif_pcr_req_valid, phase == 1); end
            checks++; if (bus.htif_pcr_resp_ready !== (phase != 3)) begin errors++; $display("FAIL rnd_htif_resp_ready cyc %0d got %b exp %b", cyc, bus.htif_pcr_resp_ready, phase != 3); end
            checks++; if (bus.resp_valid !== exp_rv) begin errors++; $display("FAIL rnd_resp_valid cyc %0d got %b exp %b", cyc, bus.resp_valid, exp_rv); end
            if (phase == 1) begin
                checks++; if (bus.htif_pcr_req_rw !== exp_rw || bus.htif_pcr_req_addr !== exp_a || bus.htif_pcr_req_data !== exp_wd) begin errors++; $display("FAIL rnd_fields cyc %0d got rw%b a%h d%h exp rw%b a%h d%h", cyc, bus.htif_pcr_req_rw, bus.htif_pcr_req_addr, bus.htif_pcr_req_data, exp_rw, exp_a, exp_wd); end
            end
            if (phase == 3) begin
                checks++; if (bus.resp_data !== exp_d) begin errors++; $display("FAIL rnd_resp_data cyc %0d got %h exp %h", cyc, bus.resp_data, exp_d); end
            end
            case (phase)
                0: if (found) begin
                    for (int i = 0; i < N; i++) if (exp_rdy[i]) cur = i;
                    pend[cur] = 1'b0;
                    exp_rw = bus.req_rw[cur];
                    exp_a = bus.req_addr[cur*12 +: 12];
                    exp_wd = bus.req_data[cur*64 +: 64];
                    phase = 1;
                end
                1: if (bus.htif_pcr_req_ready) begin
                    phase = 2;
                    cd = $urandom_range(0, 5);
                end
                2: if (resp_drv) begin
                    exp_d = bus.htif_pcr_resp_data;
                    phase = 3;
                end else cd--;
                default: if (bus.resp_ready[cur]) begin
                    phase = 0;
                    ptr = (cur + 1) % N;
                end
            endcase
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.htif_pcr_resp_valid = 1'b0;
        #1;
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL rnd_no_timeout got %b exp 0", terr); end
    endtask
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_rw = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.resp_ready = '0;
        bus.htif_pcr_req_ready = 1'b0;
        bus.htif_pcr_resp_valid = 1'b0;
        bus.htif_pcr_resp_data = '0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
